wb_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares one memory/peripheral slave port between N bus masters (dcache, LSU, icache).
- Sits between the pipeline's memory-side masters and the system bus.
- Grants are locked for a whole cycle (cyc) period, so cache-line bursts of 8 words stay atomic.
- Includes a per-transfer ack timeout that returns an error to the stalled master.

---
 rtl/wb_arbiter_if.sv | 34 +++
 rtl/wb_arbiter.sv | 106 ++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the memory-side masters, the arbiter and the shared Wishbone slave.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface wb_arbiter_if #(
   parameter int N_MASTERS = 2
);
   logic [N_MASTERS-1:0]    m_cyc_i;
   logic [N_MASTERS-1:0]    m_stb_i;
   logic [N_MASTERS-1:0]    m_we_i;
   logic [4*N_MASTERS-1:0]  m_sel_i;
   logic [32*N_MASTERS-1:0] m_adr_i;
   logic [32*N_MASTERS-1:0] m_dat_i;
   logic [31:0]             m_dat_o;
   logic [N_MASTERS-1:0]    m_ack_o;
   logic [N_MASTERS-1:0]    m_err_o;
   logic                    s_cyc_o;
   logic                    s_stb_o;
   logic                    s_we_o;
   logic [3:0]              s_sel_o;
   logic [31:0]             s_adr_o;
   logic [31:0]             s_dat_o;
   logic [31:0]             s_dat_i;
   logic                    s_ack_i;
   logic                    s_err_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
   );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: grant locked for a whole cyc period, with an optional
// per-transfer ack timeout that answers the stalled master with an error.
module wb_arbiter #(
   parameter int N_MASTERS      = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rstn_i,
   wb_arbiter_if.slave          bus,
   output logic [N_MASTERS-1:0] grant_o
);
   localparam int PW = $clog2(N_MASTERS);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]           state;
   logic [PW-1:0]        ptr;
   logic [TW-1:0]        tcnt;
   logic [PW-1:0]        gidx;
   logic [N_MASTERS-1:0] next_grant;
   logic                 in_grant;
   logic                 cyc_g;
   logic                 stb_g;
   logic                 timeout_hit;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_MASTERS; i++)
         if (grant_o[i]) gidx = PW'(i);
   end

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      logic found;
      int   idx;
      next_grant = '0;
      found      = 1'b0;
      idx        = 0;
      for (int i = 0; i < N_MASTERS; i++) begin
         idx = (int'(ptr) + i) % N_MASTERS;
         if (!found && bus.m_cyc_i[idx]) begin
            next_grant[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

   assign in_grant    = (state == GRANT);
   assign cyc_g       = in_grant & bus.m_cyc_i[gidx];
   assign stb_g       = cyc_g & bus.m_stb_i[gidx];
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && stb_g && !bus.s_ack_i && !bus.s_err_i &&
                        (tcnt == TO_LAST);

   assign bus.s_cyc_o = cyc_g;
   assign bus.s_stb_o = stb_g & ~timeout_hit;
   assign bus.s_we_o  = in_grant & bus.m_we_i[gidx];
   assign bus.s_sel_o = in_grant ? bus.m_sel_i[4*gidx +: 4]  : 4'h0;
   assign bus.s_adr_o = in_grant ? bus.m_adr_i[32*gidx +: 32] : 32'h0;
   assign bus.s_dat_o = in_grant ? bus.m_dat_i[32*gidx +: 32] : 32'h0;
   assign bus.m_dat_o = bus.s_dat_i;

   // Ack/err stay routed in the release cycle so a final ack is never lost.
   always_comb begin
      bus.m_ack_o = '0;
      bus.m_err_o = '0;
      if (in_grant) begin
         bus.m_ack_o[gidx] = bus.s_ack_i;
         bus.m_err_o[gidx] = bus.s_err_i | timeout_hit;
      end
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= IDLE;
         grant_o <= '0;
         ptr     <= '0;
         tcnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (|bus.m_cyc_i) begin
                  grant_o <= next_grant;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (!cyc_g) begin
                  state   <= IDLE;
                  grant_o <= '0;
                  ptr     <= PW'((int'(gidx) + 1) % N_MASTERS);
                  tcnt    <= '0;
               end else if (!stb_g || bus.s_ack_i || bus.s_err_i || timeout_hit) begin
                  tcnt <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a 2-master instance with a short timeout driven from a
// cycle table, and a 3-master instance for rotation order.
module tb_wb_arbiter;
   logic       clk = 1'b0;
   logic       rstn_i = 1'b0;
   logic [1:0] grant2;
   logic [2:0] grant3;
   int         nvec = 0;
   int         nfail = 0;

   wb_arbiter_if #(.N_MASTERS(2)) bus2 ();
   wb_arbiter_if #(.N_MASTERS(3)) bus3 ();

   wb_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(4)) u_dut2 (
      .clk(clk), .rstn_i(rstn_i), .bus(bus2.slave), .grant_o(grant2));
   wb_arbiter #(.N_MASTERS(3), .TIMEOUT_CYCLES(0)) u_dut3 (
      .clk(clk), .rstn_i(rstn_i), .bus(bus3.slave), .grant_o(grant3));

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  cyc;
      logic [1:0]  stb;
      logic        ack;
      logic        err;
      logic        scyc;
      logic        sstb;
      logic [31:0] sadr;
      logic [1:0]  mack;
      logic [1:0]  merr;
      logic [1:0]  gnt;
   } vec_t;

   vec_t vt[25];

   function automatic vec_t v(input logic [1:0] cyc, input logic [1:0] stb, input logic ack,
                              input logic err, input logic scyc, input logic sstb,
                              input logic [31:0] sadr, input logic [1:0] mack,
                              input logic [1:0] merr, input logic [1:0] gnt);
      vec_t r;
      r.cyc = cyc; r.stb = stb; r.ack = ack; r.err = err; r.scyc = scyc; r.sstb = sstb;
      r.sadr = sadr; r.mack = mack; r.merr = merr; r.gnt = gnt;
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // single read, pointer-ordered contention, timeout, err passthrough, ack-beats-timeout
      vt[0]  = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[1]  = v(2'b01, 2'b01, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[2]  = v(2'b01, 2'b01, 0, 0, 1, 1, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[3]  = v(2'b01, 2'b01, 1, 0, 1, 1, 32'h100, 2'b01, 2'b00, 2'b01);
      vt[4]  = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[5]  = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[6]  = v(2'b11, 2'b11, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[7]  = v(2'b11, 2'b11, 1, 0, 1, 1, 32'h200, 2'b10, 2'b00, 2'b10);
      vt[8]  = v(2'b01, 2'b01, 0, 0, 0, 0, 32'h200, 2'b00, 2'b00, 2'b10);
      vt[9]  = v(2'b01, 2'b01, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[10] = v(2'b01, 2'b01, 0, 0, 1, 1, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[11] = v(2'b01, 2'b01, 0, 0, 1, 1, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[12] = v(2'b01, 2'b01, 0, 0, 1, 1, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[13] = v(2'b01, 2'b01, 0, 0, 1, 0, 32'h100, 2'b00, 2'b01, 2'b01);
      vt[14] = v(2'b01, 2'b00, 0, 0, 1, 0, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[15] = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h100, 2'b00, 2'b00, 2'b01);
      vt[16] = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[17] = v(2'b10, 2'b10, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);
      vt[18] = v(2'b10, 2'b10, 0, 1, 1, 1, 32'h200, 2'b00, 2'b10, 2'b10);
      vt[19] = v(2'b10, 2'b10, 0, 0, 1, 1, 32'h200, 2'b00, 2'b00, 2'b10);
      vt[20] = v(2'b10, 2'b10, 0, 0, 1, 1, 32'h200, 2'b00, 2'b00, 2'b10);
      vt[21] = v(2'b10, 2'b10, 0, 0, 1, 1, 32'h200, 2'b00, 2'b00, 2'b10);
      vt[22] = v(2'b10, 2'b10, 1, 0, 1, 1, 32'h200, 2'b10, 2'b00, 2'b10);
      vt[23] = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h200, 2'b00, 2'b00, 2'b10);
      vt[24] = v(2'b00, 2'b00, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 2'b00);

      bus2.m_cyc_i = '0; bus2.m_stb_i = '0; bus2.m_we_i = '0; bus2.m_sel_i = 8'hFF;
      bus2.m_adr_i = {32'h200, 32'h100};
      bus2.m_dat_i = {32'h2222_0000, 32'h1111_0000};
      bus2.s_dat_i = 32'hDEADBEEF; bus2.s_ack_i = 1'b0; bus2.s_err_i = 1'b0;
      bus3.m_cyc_i = '0; bus3.m_stb_i = '0; bus3.m_we_i = '0; bus3.m_sel_i = '1;
      bus3.m_adr_i = {32'h300, 32'h200, 32'h100}; bus3.m_dat_i = '0;
      bus3.s_dat_i = 32'h0; bus3.s_ack_i = 1'b0; bus3.s_err_i = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset2", {bus2.s_cyc_o, bus2.s_stb_o, bus2.m_ack_o, bus2.m_err_o, grant2}, 64'h0);
      check("reset3", {bus3.s_cyc_o, bus3.m_ack_o, bus3.m_err_o, grant3}, 64'h0);
      rstn_i = 1'b1;
      step();

      for (int i = 0; i < 25; i++) begin
         bus2.m_cyc_i = vt[i].cyc;
         bus2.m_stb_i = vt[i].stb;
         bus2.s_ack_i = vt[i].ack;
         bus2.s_err_i = vt[i].err;
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {bus2.s_cyc_o, bus2.s_stb_o, bus2.s_adr_o, bus2.m_ack_o, bus2.m_err_o, grant2},
               {vt[i].scyc, vt[i].sstb, vt[i].sadr, vt[i].mack, vt[i].merr, vt[i].gnt});
         step();
      end
      bus2.s_ack_i = 1'b0;
      bus2.s_err_i = 1'b0;

      // rotation across three masters that re-request as soon as they release
      bus3.m_cyc_i = 3'b111;
      bus3.m_stb_i = 3'b111;
      for (int k = 0; k < 6; k++) begin
         int waited;
         int e;
         logic [2:0] eg;
         waited = 0;
         e = k % 3;
         eg = 3'(1 << e);
         @(negedge clk);
         while (grant3 == 3'b000 && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         check($sformatf("fair%0d", k), {bus3.s_adr_o, grant3}, {32'h100 * (e + 1), eg});
         check($sformatf("fair_err%0d", k), bus3.m_err_o, 64'h0);
         step();
         bus3.m_cyc_i[e] = 1'b0;
         bus3.m_stb_i[e] = 1'b0;
         step();
         bus3.m_cyc_i[e] = 1'b1;
         bus3.m_stb_i[e] = 1'b1;
      end
      bus3.m_cyc_i = '0;
      bus3.m_stb_i = '0;

      // 8-beat burst by master 0 while master 1 keeps requesting
      bus2.m_cyc_i = 2'b11;
      bus2.m_stb_i = 2'b11;
      @(negedge clk);
      check("burst_idle", grant2, 64'h0);
      step();
      bus2.s_ack_i = 1'b1;
      for (int b = 0; b < 8; b++) begin
         bus2.s_dat_i = 32'hDEAD_0000 + b;
         @(negedge clk);
         check($sformatf("burst%0d", b),
               {bus2.m_dat_o, bus2.s_adr_o, bus2.m_ack_o, grant2},
               {32'hDEAD_0000 + b, 32'h100, 2'b01, 2'b01});
         step();
      end
      bus2.s_ack_i = 1'b0;
      bus2.m_cyc_i = 2'b10;
      bus2.m_stb_i = 2'b10;
      @(negedge clk);
      check("burst_rel", {bus2.s_cyc_o, bus2.m_ack_o, grant2}, {1'b0, 2'b00, 2'b01});
      step();
      @(negedge clk);
      check("burst_idle2", grant2, 64'h0);
      step();
      @(negedge clk);
      check("burst_m1", {bus2.s_adr_o, grant2}, {32'h200, 2'b10});
      step();

      // master 1 write interrupted by asynchronous reset
      bus2.m_we_i = 2'b10;
      bus2.m_cyc_i = 2'b11;
      bus2.m_stb_i = 2'b11;
      @(negedge clk);
      check("wr_m1", {bus2.s_cyc_o, bus2.s_we_o, bus2.s_dat_o}, {1'b1, 1'b1, 32'h2222_0000});
      #2 rstn_i = 1'b0;
      #1;
      check("async_rst", {bus2.s_cyc_o, bus2.s_we_o, grant2}, 64'h0);
      @(negedge clk);
      rstn_i = 1'b1;
      bus2.m_we_i = 2'b00;
      step();
      @(negedge clk);
      check("post_rst_m0", grant2, 64'h1);
      step();
      bus2.m_cyc_i = 2'b10;
      bus2.m_stb_i = 2'b10;
      step();
      step();
      @(negedge clk);
      check("post_rst_m1", grant2, 64'h2);
      step();
      bus2.m_cyc_i = 2'b01;
      bus2.m_stb_i = 2'b01;
      step();
      bus2.m_cyc_i = 2'b11;
      bus2.m_stb_i = 2'b11;
      step();
      @(negedge clk);
      check("ptr_back_0", grant2, 64'h1);
      bus2.m_cyc_i = 2'b00;
      bus2.m_stb_i = 2'b00;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
